// File: rtl/fifo_async_read_ctrl.sv
// Read-domain controller for the asynchronous circular FIFO: write-pointer synchroniser,
// binary/gray read pointer, RAM read strobe, occupancy level, empty/almost-empty and sticky underflow.
module fifo_async_read_ctrl #(
    parameter int ADDR_WIDTH    = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  read_clk,
    input  logic                  nrst_in,
    input  logic                  read_in,
    input  logic                  clr_err_in,
    input  logic [ADDR_WIDTH:0]   wptr_g_in,
    output logic [ADDR_WIDTH:0]   rptr_g_out,
    output logic [ADDR_WIDTH-1:0] raddr_out,
    output logic                  read_en_out,
    output logic                  empty_out,
    output logic                  aempty_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  underflow_out
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  wptr_b_sync;

    logic [PW-1:0] rptr_b_q, rptr_b_d;
    logic [PW-1:0] rptr_g_q, rptr_g_d;
    logic [PW-1:0] level_q,  level_d;
    logic          empty_q,  empty_d;
    logic          aempty_q, aempty_d;
    logic          underflow_q, underflow_d;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage 0 samples the raw write-domain pointer; only the last stage is trusted.
    always_ff @(posedge read_clk or negedge nrst_in) begin
        if (!nrst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_g_in};
        end
    end

    assign wptr_b_sync = gray2bin(sync_q[SYNC_STAGES-1]);

    // A read is only honoured when the registered empty flag is low.
    assign read_en_out = read_in & ~empty_q;

    always_comb begin
        rptr_b_d    = rptr_b_q + {{ADDR_WIDTH{1'b0}}, read_en_out};
        rptr_g_d    = rptr_b_d ^ (rptr_b_d >> 1);
        level_d     = wptr_b_sync - rptr_b_d;
        empty_d     = (level_d == '0);
        aempty_d    = (level_d <= AE_THRESH);
        underflow_d = (read_in & empty_q) | (underflow_q & ~clr_err_in);
    end

    always_ff @(posedge read_clk or negedge nrst_in) begin
        if (!nrst_in) begin
            rptr_b_q    <= '0;
            rptr_g_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rptr_b_q    <= rptr_b_d;
            rptr_g_q    <= rptr_g_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
        end
    end

    assign rptr_g_out    = rptr_g_q;
    assign raddr_out     = rptr_b_q[ADDR_WIDTH-1:0];
    assign level_out     = level_q;
    assign empty_out     = empty_q;
    assign aempty_out    = aempty_q;
    assign underflow_out = underflow_q;

endmodule

// File: tb/tb_fifo_async_read_ctrl.sv
// Self-checking bench for fifo_async_read_ctrl: vector table, corner sequences and a
// randomized run against a count-based reference model.
module tb_fifo_async_read_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int SYNC  = 2;
    localparam int THR   = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          nrst_in;
    logic          read_in, clr_err_in;
    logic [PW-1:0] wptr_g_in;
    logic [PW-1:0] rptr_g_out;
    logic [AW-1:0] raddr_out;
    logic          read_en_out, empty_out, aempty_out, underflow_out;
    logic [PW-1:0] level_out;

    logic          read2, clr2;
    logic [PW-1:0] wptr2;
    logic [PW-1:0] rptr_g2, level2;
    logic [AW-1:0] raddr2;
    logic          ren2, empty2, aempty2, uf2;

    always #5 clk = ~clk;

    fifo_async_read_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AEMPTY_THRESH(THR)) dut (
        .read_clk(clk), .nrst_in(nrst_in), .read_in(read_in), .clr_err_in(clr_err_in),
        .wptr_g_in(wptr_g_in), .rptr_g_out(rptr_g_out), .raddr_out(raddr_out),
        .read_en_out(read_en_out), .empty_out(empty_out), .aempty_out(aempty_out),
        .level_out(level_out), .underflow_out(underflow_out)
    );

    fifo_async_read_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(3), .AEMPTY_THRESH(0)) dut2 (
        .read_clk(clk), .nrst_in(nrst_in), .read_in(read2), .clr_err_in(clr2),
        .wptr_g_in(wptr2), .rptr_g_out(rptr_g2), .raddr_out(raddr2),
        .read_en_out(ren2), .empty_out(empty2), .aempty_out(aempty2),
        .level_out(level2), .underflow_out(uf2)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: plain counts of writes/reads, write history delayed by SYNC edges.
    int hist[$];
    int mReads;
    int mLevel;
    bit mEmpty, mAempty, mUf;
    int wcnt;

    typedef struct {
        int wc;
        bit rd;
        bit cl;
        int lvl;
        bit emp;
        bit aemp;
        bit uf;
        int raddr;
        int rg;
    } vec_t;

    vec_t vecs[12];

    function automatic int gray(input int b);
        int m;
        m = b % (2 * DEPTH);
        return m ^ (m >> 1);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        mReads  = 0;
        mLevel  = 0;
        mEmpty  = 1'b1;
        mAempty = 1'b1;
        mUf     = 1'b0;
        wcnt    = 0;
    endtask

    task automatic modelStep(input bit rd, input bit cl, input int wc);
        int wv;
        bit ren;
        wv  = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 0;
        hist.push_back(wc);
        ren = rd && !mEmpty;
        mUf = (rd && mEmpty) || (mUf && !cl);
        if (ren) mReads++;
        mLevel  = wv - mReads;
        mEmpty  = (mLevel == 0);
        mAempty = (mLevel <= THR);
    endtask

    task automatic doReset();
        nrst_in    = 1'b0;
        read_in    = 1'b0;
        clr_err_in = 1'b0;
        wptr_g_in  = '0;
        read2      = 1'b0;
        clr2       = 1'b0;
        wptr2      = '0;
        modelReset();
        repeat (2) @(negedge clk);
        nrst_in = 1'b1;
    endtask

    task automatic applyStimulus(input bit rd, input bit cl, input int wc);
        @(negedge clk);
        read_in    = rd;
        clr_err_in = cl;
        wcnt       = wc;
        wptr_g_in  = PW'(gray(wc));
        #1;
        checkOutput("read_en", int'(read_en_out), int'(rd && !mEmpty));
        @(posedge clk);
        modelStep(rd, cl, wc);
        #1;
    endtask

    task automatic checkModel();
        checkOutput("level",     int'(level_out),     mLevel);
        checkOutput("empty",     int'(empty_out),     int'(mEmpty));
        checkOutput("aempty",    int'(aempty_out),    int'(mAempty));
        checkOutput("underflow", int'(underflow_out), int'(mUf));
        checkOutput("raddr",     int'(raddr_out),     mReads % DEPTH);
        checkOutput("rptr_g",    int'(rptr_g_out),    gray(mReads));
    endtask

    initial begin
        //           wc rd cl lvl emp aemp uf raddr rg
        vecs[0]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{2, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[2]  = '{3, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[3]  = '{3, 0, 0, 2, 0, 1, 0, 0, 0};
        vecs[4]  = '{3, 0, 0, 3, 0, 0, 0, 0, 0};
        vecs[5]  = '{3, 1, 0, 2, 0, 1, 0, 1, 1};
        vecs[6]  = '{3, 1, 0, 1, 0, 1, 0, 2, 3};
        vecs[7]  = '{3, 1, 0, 0, 1, 1, 0, 3, 2};
        vecs[8]  = '{3, 1, 0, 0, 1, 1, 1, 3, 2};
        vecs[9]  = '{3, 1, 1, 0, 1, 1, 1, 3, 2};
        vecs[10] = '{3, 0, 1, 0, 1, 1, 0, 3, 2};
        vecs[11] = '{3, 0, 0, 0, 1, 1, 0, 3, 2};

        doReset();
        #1;
        checkOutput("rst_empty", int'(empty_out), 1);
        checkOutput("rst_level", int'(level_out), 0);

        // Fill/drain/underflow vector table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].cl, vecs[i].wc);
            checkOutput($sformatf("vec%0d_level", i),  int'(level_out),     vecs[i].lvl);
            checkOutput($sformatf("vec%0d_empty", i),  int'(empty_out),     int'(vecs[i].emp));
            checkOutput($sformatf("vec%0d_aempty", i), int'(aempty_out),    int'(vecs[i].aemp));
            checkOutput($sformatf("vec%0d_uf", i),     int'(underflow_out), int'(vecs[i].uf));
            checkOutput($sformatf("vec%0d_raddr", i),  int'(raddr_out),     vecs[i].raddr);
            checkOutput($sformatf("vec%0d_rptrg", i),  int'(rptr_g_out),    vecs[i].rg);
        end

        // Full level: 8 writes, settle, then 8 reads
        doReset();
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 1'b0, i);
        repeat (SYNC + 1) applyStimulus(1'b0, 1'b0, DEPTH);
        checkOutput("full_level", int'(level_out), DEPTH);
        checkOutput("full_empty", int'(empty_out), 0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, DEPTH);
            checkModel();
        end
        checkOutput("drain_empty", int'(empty_out), 1);
        checkOutput("drain_rptrg", int'(rptr_g_out), 12);

        // Randomized traffic, wraps the pointers many times
        doReset();
        for (int i = 0; i < 400; i++) begin
            int wc;
            bit rd, cl;
            wc = wcnt;
            if ((wc - mReads) < DEPTH && $urandom_range(0, 99) < 55) wc++;
            rd = ($urandom_range(0, 99) < 50);
            cl = ($urandom_range(0, 99) < 10);
            applyStimulus(rd, cl, wc);
            checkModel();
        end

        // Asynchronous reset mid-cycle while a read is pending
        @(posedge clk);
        #3;
        read_in = 1'b1;
        nrst_in = 1'b0;
        #1;
        checkOutput("async_rst_level",  int'(level_out),     0);
        checkOutput("async_rst_empty",  int'(empty_out),     1);
        checkOutput("async_rst_aempty", int'(aempty_out),    1);
        checkOutput("async_rst_uf",     int'(underflow_out), 0);
        checkOutput("async_rst_raddr",  int'(raddr_out),     0);
        checkOutput("async_rst_rptrg",  int'(rptr_g_out),    0);
        checkOutput("async_rst_ren",    int'(read_en_out),   0);

        // SYNC_STAGES=3, AEMPTY_THRESH=0: flags follow after the 4th edge
        doReset();
        @(negedge clk);
        wptr2 = PW'(gray(1));
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("sweep_e%0d_empty", e), int'(empty2), (e < 4) ? 1 : 0);
            checkOutput($sformatf("sweep_e%0d_aempty", e), int'(aempty2), int'(empty2));
        end
        checkOutput("sweep_level", int'(level2), 1);
        @(negedge clk);
        read2 = 1'b1;
        @(posedge clk);
        #1;
        read2 = 1'b0;
        checkOutput("sweep_drain_empty",  int'(empty2),  1);
        checkOutput("sweep_drain_aempty", int'(aempty2), 1);
        checkOutput("sweep_drain_raddr",  int'(raddr2),  1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
